vectored_interrupt_ctrl: RTL



---
 rtl/vectored_interrupt_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vectored_interrupt_ctrl.sv
// Purpose: priority-based nesting interrupt unit that redirects fetch to per-source vectors and restores PCs from a return stack.
// Latency: a request rising at edge E redirects pc_next_final combinationally in the cycle after E; a return restores the PC in its own cycle.
// Backpressure: none; the PC path is never stalled. A full stack or lower-priority sources leave requests pending until eligible.
// Optional feature: define ICU_TAIL_CHAIN_EN to chain straight into an eligible source on return instead of popping first.
module vectored_interrupt_ctrl #(
  parameter int          NUM_IRQ       = 4,
  parameter int          PC_WIDTH      = 32,
  parameter int          NEST_DEPTH    = 2,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
  parameter int          VECTOR_STRIDE = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [PC_WIDTH-1:0]               pc_next,
  input  logic [NUM_IRQ-1:0]                irq_req,
  input  logic [NUM_IRQ-1:0]                irq_enable,
  input  logic                              global_ie,
  input  logic                              return_from_isr,
  output logic [PC_WIDTH-1:0]               pc_next_final,
  output logic [PC_WIDTH-1:0]               pc_next_regfile,
  output logic                              en_regfile,
  output logic                              isr_active,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   depth,
  output logic                              stack_full
);

  localparam int DW = $clog2(NEST_DEPTH + 1);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0]  pending;
  logic [NUM_IRQ-1:0]  irq_req_prev;
  logic [PC_WIDTH-1:0] stack_pc [NEST_DEPTH];
  logic [IW-1:0]       stack_id [NEST_DEPTH];

  logic [IW-1:0]       top_id;
  logic [PC_WIDTH-1:0] top_pc;
  logic [NUM_IRQ-1:0]  elig_now;
  logic [IW-1:0]       win_now;
  logic                any_now;
  logic                ret;
  logic                take;
  logic                chain;
  logic [IW-1:0]       chain_id;
  logic [NUM_IRQ-1:0]  clr_mask;
  logic [NUM_IRQ-1:0]  rise;

  function automatic logic [PC_WIDTH-1:0] vector_of(input logic [IW-1:0] id);
    return PC_WIDTH'(VECTOR_BASE) + PC_WIDTH'(id) * PC_WIDTH'(VECTOR_STRIDE);
  endfunction

  assign isr_active = (depth != '0);
  assign stack_full = (int'(depth) == NEST_DEPTH);
  assign rise       = irq_req & ~irq_req_prev;

  // Read the top-of-stack entry (valid only when depth > 0).
  always_comb begin
    top_id = '0;
    top_pc = '0;
    for (int k = 0; k < NEST_DEPTH; k++) begin
      if (int'(depth) == k + 1) begin
        top_id = stack_id[k];
        top_pc = stack_pc[k];
      end
    end
  end

  // Eligibility against the current stack, then pick the lowest index.
  always_comb begin
    elig_now = '0;
    win_now  = '0;
    any_now  = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      elig_now[i] = pending[i] && irq_enable[i] && global_ie &&
                    (int'(depth) < NEST_DEPTH) &&
                    ((depth == '0) || (i < int'(top_id)));
    end
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig_now[i]) begin
        win_now = IW'(i);
        any_now = 1'b1;
      end
    end
  end

  // A return at depth 0 is ignored, so it neither pops nor blocks a take.
  assign ret  = return_from_isr && (depth != '0);
  assign take = any_now && !ret;

`ifdef ICU_TAIL_CHAIN_EN
  logic [IW-1:0]      under_id;
  logic [NUM_IRQ-1:0] elig_pop;
  logic               any_pop;

  // Eligibility as it would stand after the pop: one level shallower, new top below.
  always_comb begin
    under_id = '0;
    elig_pop = '0;
    chain_id = '0;
    any_pop  = 1'b0;
    for (int k = 0; k < NEST_DEPTH; k++) begin
      if (int'(depth) == k + 2) under_id = stack_id[k];
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      elig_pop[i] = pending[i] && irq_enable[i] && global_ie &&
                    ((int'(depth) == 1) || (i < int'(under_id)));
    end
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig_pop[i]) begin
        chain_id = IW'(i);
        any_pop  = 1'b1;
      end
    end
  end

  assign chain = ret && any_pop;
`else
  assign chain    = 1'b0;
  assign chain_id = '0;
`endif

  // Pending bit consumed by a take or a chained return.
  always_comb begin
    clr_mask = '0;
    if (take)       clr_mask[win_now]  = 1'b1;
    else if (chain) clr_mask[chain_id] = 1'b1;
  end

  // PC steering: return beats take; reset forces pass-through.
  always_comb begin
    pc_next_final   = pc_next;
    pc_next_regfile = '0;
    en_regfile      = 1'b0;
    if (!reset) begin
      if (ret) begin
        pc_next_final = chain ? vector_of(chain_id) : top_pc;
      end else if (take) begin
        pc_next_final   = vector_of(win_now);
        pc_next_regfile = pc_next;
        en_regfile      = 1'b1;
      end
    end
  end

  // Edge capture, pending bookkeeping and return-stack push/pop/retag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      irq_req_prev <= '0;
      depth        <= '0;
      for (int k = 0; k < NEST_DEPTH; k++) begin
        stack_pc[k] <= '0;
        stack_id[k] <= '0;
      end
    end else begin
      irq_req_prev <= irq_req;
      // New edges are OR-ed in after the clear so a same-cycle set wins.
      pending      <= (pending & ~clr_mask) | rise;
      if (ret) begin
        if (chain) begin
          // Keep the outer return PC, just retag the level with the chained source.
          for (int k = 0; k < NEST_DEPTH; k++) begin
            if (int'(depth) == k + 1) stack_id[k] <= chain_id;
          end
        end else begin
          depth <= depth - DW'(1);
        end
      end else if (take) begin
        for (int k = 0; k < NEST_DEPTH; k++) begin
          if (int'(depth) == k) begin
            stack_pc[k] <= pc_next;
            stack_id[k] <= win_now;
          end
        end
        depth <= depth + DW'(1);
      end
    end
  end

endmodule
